// File: rtl/press_counter_bcd_if.sv
// Button/display bundle between the board top level and press_counter_bcd.
// Latency: none, wires only.
// Backpressure: none; level inputs and continuously driven display outputs.
interface press_counter_bcd_if;
  logic       i_btn_db;
  logic       i_dir;
  logic       i_clr;
  logic [7:0] o_hex0;
  logic [7:0] o_hex1;
  logic [7:0] o_hex2;
  logic [7:0] o_hex3;
  logic       o_press;
  logic       o_ovf;

  // Counter side: consumes the button/control levels, drives the display.
  modport slave (
    input  i_btn_db, i_dir, i_clr,
    output o_hex0, o_hex1, o_hex2, o_hex3, o_press, o_ovf
  );

  // Board/bench side: drives the button/control levels, observes the display.
  modport master (
    output i_btn_db, i_dir, i_clr,
    input  o_hex0, o_hex1, o_hex2, o_hex3, o_press, o_ovf
  );
endinterface

// File: rtl/press_counter_bcd.sv
// 4-digit BCD up/down press counter with active-low 7-segment decode.
// Latency: count/PRESS/OVF update on the first edge sampling a press; HEX is comb.
// Backpressure: none; every press edge is counted (or discarded by CLR/RST).
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits on
// HEX3..HEX1 (HEX0 always shown). Counting, PRESS and OVF are the same either way.
module press_counter_bcd #(
  parameter logic       PRESS_LEVEL = 1'b0,
  parameter logic [3:0] MAX_DIGIT   = 4'd9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  press_counter_bcd_if.slave    bus
);

  logic       r_btn_prev;
  logic [3:0] r_d [4];
  logic       r_press;
  logic       r_ovf;

  logic       w_press;
  logic [3:0] w_nxt [4];
  logic       w_carry;
  logic       w_wrap;

  // Digit value to active-low {dp,g,f,e,d,c,b,a}; non-BCD shows a dash.
  function automatic logic [7:0] f_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // A press is a released-to-pressed transition between consecutive samples.
  assign w_press = (r_btn_prev != PRESS_LEVEL) && (bus.i_btn_db == PRESS_LEVEL);

  // Ripple the +1/-1 through the digits; carry out of the top digit is a wrap.
  always_comb begin
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_nxt[i] = r_d[i];
      if (w_carry) begin
        if (bus.i_dir) begin
          if (r_d[i] >= MAX_DIGIT) begin
            w_nxt[i] = 4'd0;
          end else begin
            w_nxt[i] = r_d[i] + 4'd1;
            w_carry  = 1'b0;
          end
        end else begin
          if (r_d[i] == 4'd0) begin
            w_nxt[i] = MAX_DIGIT;
          end else begin
            w_nxt[i] = r_d[i] - 4'd1;
            w_carry  = 1'b0;
          end
        end
      end
    end
    w_wrap = w_carry;
  end

  // State update: RST over CLR over press; the button history always tracks
  // the input so a button held through reset or clear is not counted later.
  always_ff @(posedge i_clk) begin
    r_btn_prev <= bus.i_btn_db;
    if (i_rst) begin
      for (int i = 0; i < 4; i++) r_d[i] <= 4'd0;
      r_press <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.i_clr) begin
      for (int i = 0; i < 4; i++) r_d[i] <= 4'd0;
      r_press <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_press <= w_press;
      if (w_press) begin
        for (int i = 0; i < 4; i++) r_d[i] <= w_nxt[i];
        if (w_wrap) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.o_press = r_press;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_hex0  = f_seg(r_d[0]);

`ifdef LEADING_ZERO_BLANK_EN
  logic w_blank3;
  logic w_blank2;
  logic w_blank1;

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    w_blank3 = (r_d[3] == 4'd0);
    w_blank2 = w_blank3 && (r_d[2] == 4'd0);
    w_blank1 = w_blank2 && (r_d[1] == 4'd0);
  end

  assign bus.o_hex1 = w_blank1 ? 8'hFF : f_seg(r_d[1]);
  assign bus.o_hex2 = w_blank2 ? 8'hFF : f_seg(r_d[2]);
  assign bus.o_hex3 = w_blank3 ? 8'hFF : f_seg(r_d[3]);
`else
  assign bus.o_hex1 = f_seg(r_d[1]);
  assign bus.o_hex2 = f_seg(r_d[2]);
  assign bus.o_hex3 = f_seg(r_d[3]);
`endif

endmodule

// File: tb/tb_press_counter_bcd.sv
// Bench for press_counter_bcd: directed scenarios plus random stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_press_counter_bcd;

  localparam logic PL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model state: decimal count, sticky wrap, last pulse, last sample.
  int m_count = 0;
  bit m_ovf   = 1'b0;
  bit m_press = 1'b0;
  bit m_prev  = 1'b1;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] dut_hex [4];

  press_counter_bcd_if bus_if ();

  press_counter_bcd #(.PRESS_LEVEL(PL), .MAX_DIGIT(4'd9)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  assign dut_hex[0] = bus_if.o_hex0;
  assign dut_hex[1] = bus_if.o_hex1;
  assign dut_hex[2] = bus_if.o_hex2;
  assign dut_hex[3] = bus_if.o_hex3;

  // Expected display of digit k for the model count.
  function automatic logic [7:0] exp_hex(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && m_count < p) return 8'hFF;
`endif
    return seg_tab[(m_count / p) % 10];
  endfunction

  // Advance one clock; the model consumes the same inputs the DUT samples.
  task automatic tick();
    if (rst || bus_if.i_clr) begin
      m_count = 0;
      m_ovf   = 1'b0;
      m_press = 1'b0;
    end else begin
      m_press = (m_prev != PL) && (bus_if.i_btn_db == PL);
      if (m_press) begin
        if (bus_if.i_dir) begin
          if (m_count == 9999) begin m_count = 0; m_ovf = 1'b1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = 9999; m_ovf = 1'b1; end
          else m_count = m_count - 1;
        end
      end
    end
    m_prev = bus_if.i_btn_db;
    @(posedge clk);
    #1;
  endtask

  task automatic press_once();
    bus_if.i_btn_db = PL;
    tick();
    bus_if.i_btn_db = ~PL;
    tick();
  endtask

  task automatic clr_pulse();
    bus_if.i_clr = 1'b1;
    tick();
    bus_if.i_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int npress = 0;
    rst = 1'b1;
    bus_if.i_btn_db = PL;
    bus_if.i_dir = 1'b1;
    bus_if.i_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (bus_if.o_press) npress++;
    end
    checks++;
    if (npress !== 0) begin errors++; $display("FAIL reset_press got %0d pulses want 0", npress); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dut_hex[k] !== 8'hC0) begin errors++; $display("FAIL reset_hex%0d got %h want c0", k, dut_hex[k]); end
    end
    checks++;
    if (bus_if.o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus_if.o_ovf); end
  endtask

  task automatic test_count_up();
    int nhigh = 0;
    bus_if.i_btn_db = ~PL;
    repeat (2) tick();
    bus_if.i_dir = 1'b1;
    for (int p = 0; p < 12; p++) begin
      bus_if.i_btn_db = PL;
      repeat (5) begin tick(); if (bus_if.o_press) nhigh++; end
      bus_if.i_btn_db = ~PL;
      repeat (5) begin tick(); if (bus_if.o_press) nhigh++; end
    end
    checks++;
    if (nhigh !== 12) begin errors++; $display("FAIL up12_press_cycles got %0d want 12", nhigh); end
    checks++;
    if (bus_if.o_hex1 !== 8'hF9) begin errors++; $display("FAIL up12_hex1 got %h want f9", bus_if.o_hex1); end
    checks++;
    if (bus_if.o_hex0 !== 8'hA4) begin errors++; $display("FAIL up12_hex0 got %h want a4", bus_if.o_hex0); end
    checks++;
    if (bus_if.o_ovf !== 1'b0) begin errors++; $display("FAIL up12_ovf got %b want 0", bus_if.o_ovf); end
  endtask

  task automatic test_wrap_up();
    logic [7:0] top0;
`ifdef LEADING_ZERO_BLANK_EN
    top0 = 8'hFF;
`else
    top0 = 8'hC0;
`endif
    clr_pulse();
    bus_if.i_dir = 1'b1;
    repeat (9998) press_once();
    checks++;
    if ({bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0} !== 32'h90909080 || bus_if.o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL wrap_9998 got %h%h%h%h ovf %b want 90909080 ovf 0",
               bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0, bus_if.o_ovf);
    end
    press_once();
    checks++;
    if (bus_if.o_hex0 !== 8'h90 || bus_if.o_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_9999 got hex0 %h ovf %b want 90 ovf 0", bus_if.o_hex0, bus_if.o_ovf);
    end
    bus_if.i_btn_db = PL;
    tick();
    checks++;
    if (bus_if.o_press !== 1'b1) begin errors++; $display("FAIL wrap_press got %b want 1", bus_if.o_press); end
    bus_if.i_btn_db = ~PL;
    tick();
    checks++;
    if (bus_if.o_hex0 !== 8'hC0 || bus_if.o_hex3 !== top0 || bus_if.o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_0000 got hex3 %h hex0 %h ovf %b want %h c0 ovf 1",
               bus_if.o_hex3, bus_if.o_hex0, bus_if.o_ovf, top0);
    end
    clr_pulse();
    checks++;
    if (bus_if.o_hex0 !== 8'hC0 || bus_if.o_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_clr got hex0 %h ovf %b want c0 ovf 0", bus_if.o_hex0, bus_if.o_ovf);
    end
  endtask

  task automatic test_count_down();
    clr_pulse();
    bus_if.i_dir = 1'b0;
    press_once();
    checks++;
    if ({bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0} !== 32'h90909090 || bus_if.o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL down_9999 got %h%h%h%h ovf %b want 90909090 ovf 1",
               bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0, bus_if.o_ovf);
    end
    press_once();
    checks++;
    if (bus_if.o_hex0 !== 8'h80 || bus_if.o_hex1 !== 8'h90 || bus_if.o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL down_9998 got hex1 %h hex0 %h ovf %b want 90 80 ovf 1",
               bus_if.o_hex1, bus_if.o_hex0, bus_if.o_ovf);
    end
  endtask

  task automatic test_clr_collide();
    int npress = 0;
    clr_pulse();
    bus_if.i_dir = 1'b1;
    repeat (5) press_once();
    checks++;
    if (bus_if.o_hex0 !== 8'h92) begin errors++; $display("FAIL collide_pre got hex0 %h want 92", bus_if.o_hex0); end
    bus_if.i_btn_db = PL;
    bus_if.i_clr = 1'b1;
    tick();
    bus_if.i_clr = 1'b0;
    checks++;
    if (bus_if.o_press !== 1'b0 || bus_if.o_hex0 !== 8'hC0) begin
      errors++; $display("FAIL collide_clr got press %b hex0 %h want 0 c0", bus_if.o_press, bus_if.o_hex0);
    end
    repeat (1000) begin tick(); if (bus_if.o_press) npress++; end
    checks++;
    if (npress !== 0 || bus_if.o_hex0 !== 8'hC0) begin
      errors++; $display("FAIL collide_hold got %0d pulses hex0 %h want 0 c0", npress, bus_if.o_hex0);
    end
    bus_if.i_btn_db = ~PL;
    tick();
  endtask

  task automatic test_blank();
    logic [31:0] want7;
    logic [31:0] want100;
`ifdef LEADING_ZERO_BLANK_EN
    want7   = 32'hFFFFFFF8;
    want100 = 32'hFFF9C0C0;
`else
    want7   = 32'hC0C0C0F8;
    want100 = 32'hC0F9C0C0;
`endif
    clr_pulse();
    bus_if.i_dir = 1'b1;
    repeat (7) press_once();
    checks++;
    if ({bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0} !== want7) begin
      errors++;
      $display("FAIL display_7 got %h%h%h%h want %h",
               bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0, want7);
    end
    repeat (93) press_once();
    checks++;
    if ({bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0} !== want100) begin
      errors++;
      $display("FAIL display_100 got %h%h%h%h want %h",
               bus_if.o_hex3, bus_if.o_hex2, bus_if.o_hex1, bus_if.o_hex0, want100);
    end
  endtask

  task automatic test_back_to_back();
    int npress = 0;
    clr_pulse();
    bus_if.i_dir = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus_if.i_btn_db = (c % 2 == 0) ? PL : ~PL;
      tick();
      if (bus_if.o_press) npress++;
    end
    checks++;
    if (npress !== 10 || bus_if.o_hex1 !== 8'hF9 || bus_if.o_hex0 !== 8'hC0) begin
      errors++;
      $display("FAIL b2b got %0d pulses hex1 %h hex0 %h want 10 f9 c0", npress, bus_if.o_hex1, bus_if.o_hex0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) bus_if.i_btn_db = ~bus_if.i_btn_db;
      bus_if.i_dir = ($urandom_range(0, 3) != 0) ? ~bus_if.i_dir : bus_if.i_dir;
      bus_if.i_clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (bus_if.o_press !== m_press || bus_if.o_ovf !== m_ovf) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got press %b ovf %b want %b %b",
                 c, bus_if.o_press, bus_if.o_ovf, m_press, m_ovf);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_hex[k] !== exp_hex(k)) begin
          errors++;
          $display("FAIL rand_hex%0d cyc %0d count %0d got %h want %h", k, c, m_count, dut_hex[k], exp_hex(k));
        end
      end
    end
    rst = 1'b0;
    bus_if.i_clr = 1'b0;
  endtask

  initial begin
    bus_if.i_btn_db = PL;
    bus_if.i_dir = 1'b1;
    bus_if.i_clr = 1'b0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_clr_collide();
    test_blank();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
